// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath (synaptic sum, potential, spike stages).
// Holds the width derivation, the pass FSM encoding and the saturation bounds.
package neuron_pkg;

   localparam int unsigned N_STAGE_DEF = 6;

   // Datapath width used by every stage: two guard bits above n_stage.
   function automatic int unsigned calc_w(input int unsigned n_stage);
      return n_stage + 2;
   endfunction

   // Signed two's-complement bounds for a w-bit datapath.
   function automatic int sat_max(input int unsigned w);
      return (1 <<< (w - 1)) - 1;
   endfunction

   function automatic int sat_min(input int unsigned w);
      return -(1 <<< (w - 1));
   endfunction

   localparam int unsigned W_DEF   = calc_w(N_STAGE_DEF);
   localparam int          SAT_MAX = sat_max(W_DEF);
   localparam int          SAT_MIN = sat_min(W_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/synapse_weight_rf.sv
// Synaptic weight register file: n_syn x W flops, one synchronous write port,
// one asynchronous read port, asynchronous active-low clear.
// Ports: clk, rst_n, wr_en/wr_addr/wr_data (write), idx (read index), weight (read data).
module synapse_weight_rf #(
   parameter int unsigned n_syn = 8,
   parameter int unsigned W     = 8,
   parameter int unsigned A     = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [A-1:0] wr_addr,
   input  logic [W-1:0] wr_data,
   input  logic [A-1:0] idx,
   output logic [W-1:0] weight
);

   logic [W-1:0] mem [n_syn];

   // Addresses at or beyond n_syn are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(n_syn); k++) begin
            mem[k] <= '0;
         end
      end else if (wr_en && (32'(wr_addr) < 32'(n_syn))) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read sees the pre-write contents when read and write collide.
   assign weight = mem[idx];

endmodule

// File: rtl/synapse_sum_acc.sv
// Serial synaptic accumulator: on start, latches the spike vector and walks it
// one synapse per cycle, adding the weight of each firing synapse with
// per-step saturation; the result is presented with a one-cycle valid pulse.
// Ports: clk, rst_n; wr_en/wr_addr/wr_data program weights; start/spikes_in
// launch a pass; sum_wx/sat_flag hold the last result; sum_valid pulses when
// they update; busy is high while a pass is in progress.
module synapse_sum_acc
   import neuron_pkg::*;
#(
   parameter  int unsigned n_stage = N_STAGE_DEF,
   parameter  int unsigned n_syn   = 8,
   localparam int unsigned W       = calc_w(n_stage),
   localparam int unsigned A       = (n_syn > 1) ? $clog2(n_syn) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [A-1:0]     wr_addr,
   input  logic [W-1:0]     wr_data,
   input  logic             start,
   input  logic [n_syn-1:0] spikes_in,
   output logic [W-1:0]     sum_wx,
   output logic             sum_valid,
   output logic             sat_flag,
   output logic             busy
);

   localparam logic [W-1:0] SAT_MAX_W = W'(sat_max(W));
   localparam logic [W-1:0] SAT_MIN_W = W'(sat_min(W));
   localparam logic [A-1:0] IDX_LAST  = A'(n_syn - 1);

   state_t             state, state_nx;
   logic [A-1:0]       idx, idx_nx;
   logic [n_syn-1:0]   spikes_q, spikes_nx;
   logic [W-1:0]       acc, acc_nx;
   logic               sat_q, sat_nx;
   logic [W-1:0]       sum_nx;
   logic               sat_flag_nx;
   logic               sum_valid_nx;
   logic               busy_nx;

   logic [W-1:0]       weight;
   logic [W:0]         sum_ext;
   logic               pos_ovf, neg_ovf;
   logic [W-1:0]       add_res;

   synapse_weight_rf #(
      .n_syn (n_syn),
      .W     (W),
      .A     (A)
   ) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .idx     (idx),
      .weight  (weight)
   );

   // Saturating add: form the sum one bit wider, clamp when the top two bits disagree.
   always_comb begin
      sum_ext = {acc[W-1], acc} + {weight[W-1], weight};
      pos_ovf = ~sum_ext[W] &  sum_ext[W-1];
      neg_ovf =  sum_ext[W] & ~sum_ext[W-1];
      if (pos_ovf) begin
         add_res = SAT_MAX_W;
      end else if (neg_ovf) begin
         add_res = SAT_MIN_W;
      end else begin
         add_res = sum_ext[W-1:0];
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      spikes_nx    = spikes_q;
      acc_nx       = acc;
      sat_nx       = sat_q;
      sum_nx       = sum_wx;
      sat_flag_nx  = sat_flag;
      sum_valid_nx = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               spikes_nx = spikes_in;
               acc_nx    = '0;
               sat_nx    = 1'b0;
               idx_nx    = '0;
               state_nx  = ACC;
            end
         end
         ACC: begin
            if (spikes_q[idx]) begin
               acc_nx = add_res;
               if (pos_ovf || neg_ovf) begin
                  sat_nx = 1'b1;
               end
            end
            if (idx == IDX_LAST) begin
               idx_nx   = '0;
               state_nx = DONE;
            end else begin
               idx_nx = idx + A'(1);
            end
         end
         DONE: begin
            sum_nx       = acc;
            sat_flag_nx  = sat_q;
            sum_valid_nx = 1'b1;
            state_nx     = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      busy_nx = (state_nx != IDLE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         spikes_q  <= '0;
         acc       <= '0;
         sat_q     <= 1'b0;
         sum_wx    <= '0;
         sat_flag  <= 1'b0;
         sum_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         spikes_q  <= spikes_nx;
         acc       <= acc_nx;
         sat_q     <= sat_nx;
         sum_wx    <= sum_nx;
         sat_flag  <= sat_flag_nx;
         sum_valid <= sum_valid_nx;
         busy      <= busy_nx;
      end
   end

endmodule

// File: tb/tb_synapse_sum_acc.sv
// Scoreboard bench for synapse_sum_acc: each launched pass pushes its expected
// result (from an arithmetic reference model) into a queue; an independent
// monitor pops and compares whenever sum_valid is seen.
module tb_synapse_sum_acc;

   localparam int N  = 8;
   localparam int W  = 8;
   localparam int HI = 2 ** (W - 1) - 1;
   localparam int LO = -(2 ** (W - 1));

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         wr_en = 1'b0;
   logic [2:0]   wr_addr = '0;
   logic [W-1:0] wr_data = '0;
   logic         start = 1'b0;
   logic [N-1:0] spikes_in = '0;
   logic [W-1:0] sum_wx;
   logic         sum_valid;
   logic         sat_flag;
   logic         busy;

   synapse_sum_acc #(.n_stage(6), .n_syn(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .spikes_in (spikes_in),
      .sum_wx    (sum_wx),
      .sum_valid (sum_valid),
      .sat_flag  (sat_flag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int wmod [N];

   typedef struct {
      int sum;
      bit sat;
      int edge_n;
   } exp_t;
   exp_t q[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: ascending-order sum of fired weights, clamped after every add.
   function automatic void model(input logic [N-1:0] sp, output int s, output bit sat);
      s   = 0;
      sat = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (sp[k]) begin
            s = s + wmod[k];
            if (s > HI) begin s = HI; sat = 1'b1; end
            if (s < LO) begin s = LO; sat = 1'b1; end
         end
      end
   endfunction

   // Monitor: every valid pulse must match the oldest outstanding pass.
   always @(negedge clk) begin
      if (rst_n && sum_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got pulse with sum_wx=%0d, expected none", $signed(sum_wx));
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sum_wx", int'($signed(sum_wx)), e.sum);
            chk("sat_flag", int'(sat_flag), int'(e.sat));
            chk("latency", cyc - e.edge_n, N + 1);
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_sum_wx"}, int'(sum_wx), 0);
      chk({tag, "_sat_flag"}, int'(sat_flag), 0);
      chk({tag, "_sum_valid"}, int'(sum_valid), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   task automatic wr(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = 3'(a);
      wr_data = W'(d);
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (a < N) wmod[a] = d;
   endtask

   // mode 0: plain pass; 1: re-start and flipped spikes mid-pass; 2: rewrite w[3] while idx=3.
   task automatic run_pass(input logic [N-1:0] sp, input int mode, input int newv);
      int   s;
      bit   st;
      int   busy_cnt;
      exp_t e;
      busy_cnt = 0;
      model(sp, s, st);
      e.sum = s; e.sat = st; e.edge_n = cyc + 1;
      q.push_back(e);
      start     = 1'b1;
      spikes_in = sp;
      for (int j = 0; j < 12; j++) begin
         @(posedge clk); #1;
         if (j == 0) start = 1'b0;
         if (mode == 1 && j == 2) begin start = 1'b1; spikes_in = ~sp; end
         if (mode == 1 && j == 3) start = 1'b0;
         if (mode == 2 && j == 3) begin wr_en = 1'b1; wr_addr = 3'd3; wr_data = W'(newv); end
         if (mode == 2 && j == 4) begin wr_en = 1'b0; wmod[3] = newv; end
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      @(posedge clk); #1;
      chk("busy_cycles", busy_cnt, N + 1);
   endtask

   initial begin
      for (int k = 0; k < N; k++) wmod[k] = 0;

      // Reset with random inputs toggling.
      #2 rst_n = 1'b0;
      #1 check_zero("rst_async");
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         wr_en     = 1'($urandom);
         wr_addr   = 3'($urandom);
         wr_data   = W'($urandom);
         start     = 1'($urandom);
         spikes_in = N'($urandom);
         @(negedge clk);
         check_zero("rst_hold");
      end
      @(posedge clk); #1;
      wr_en = 1'b0; start = 1'b0; spikes_in = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Weights are zero after reset.
      run_pass(8'hFF, 0, 0);

      // Basic sum: w[k]=k+1, spikes 1010_1010 -> 20.
      for (int k = 0; k < N; k++) wr(k, k + 1);
      run_pass(8'hAA, 0, 0);

      // Positive saturation.
      for (int k = 0; k < N; k++) wr(k, 100);
      run_pass(8'hFF, 0, 0);

      // Negative saturation.
      wr(0, -128); wr(1, -128);
      run_pass(8'h03, 0, 0);

      // Order dependence: 100+100 clamps to 127, then -100 gives 27.
      wr(0, 100); wr(1, 100); wr(2, -100);
      for (int k = 3; k < N; k++) wr(k, 0);
      run_pass(8'h07, 0, 0);

      // Start and spike changes during a pass are ignored.
      for (int k = 0; k < N; k++) wr(k, int'($urandom_range(0, 255)) - 128);
      run_pass(8'h5C, 1, 0);

      // Write w[3] while idx=3: old value this pass, new value next pass.
      wr(3, 40);
      run_pass(8'h0F, 2, -50);
      run_pass(8'h0F, 0, 0);

      // Reset mid-pass at idx=4.
      start = 1'b1; spikes_in = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_zero("rst_mid");
      for (int k = 0; k < N; k++) wmod[k] = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0 || i == 11) chk("no_valid_after_abort", int'(sum_valid), 0);
      end
      @(posedge clk); #1;
      run_pass(8'hFF, 0, 0);
      for (int k = 0; k < N; k++) wr(k, k + 1);
      run_pass(8'hAA, 0, 0);

      // Randomized passes.
      for (int i = 0; i < 20; i++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 1) == 1) wr(k, int'($urandom_range(0, 255)) - 128);
         end
         run_pass(N'($urandom), 0, 0);
      end

      repeat (3) @(posedge clk);
      chk("pending_results", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
